// File: rtl/mode_picker_pkg.sv
// Shared types and scoring arithmetic for the mode_picker rate-distortion sequencer.
package mode_picker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_SCORE,
    ST_COMP,
    ST_DONE
  } state_t;

  localparam int MAX_MODES = 16;
  localparam int CALC_W    = 128;
  localparam logic [CALC_W-1:0] SCORE_SAT = '1;

  // Full-width score, clamped to the largest value representable in score_w bits.
  function automatic logic [CALC_W-1:0] calc_score(
    input logic [31:0] rate,
    input logic [15:0] fixed_cost,
    input logic [31:0] lambda,
    input logic [31:0] sse,
    input logic [31:0] disto,
    input logic [31:0] tlambda,
    input int          rate_shift,
    input int          dist_shift,
    input int          score_w
  );
    logic [CALC_W-1:0] rate_term;
    logic [CALC_W-1:0] dist_term;
    logic [CALC_W-1:0] spec_term;
    logic [CALC_W-1:0] sum;
    logic [CALC_W-1:0] limit;
    rate_term = ((CALC_W'(rate) << rate_shift) + CALC_W'(fixed_cost)) * CALC_W'(lambda);
    dist_term = CALC_W'(sse) << dist_shift;
    spec_term = CALC_W'(disto) * CALC_W'(tlambda);
    sum       = rate_term + dist_term + spec_term;
    limit     = SCORE_SAT >> (CALC_W - score_w);
    return (sum > limit) ? limit : sum;
  endfunction

endpackage

// File: rtl/mode_picker_join.sv
// Sticky-flag join of engine completion pulses; flags accumulate only while enabled.
module mode_picker_join
  import mode_picker_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [N-1:0] pulse,
  output logic         all_done
);

  logic [N-1:0] flags_q;
  logic [N-1:0] flags_d;
  logic [N-1:0] seen;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_seen
      assign seen[gi] = flags_q[gi] | pulse[gi];
    end
  endgenerate

  always_comb begin
    flags_d = flags_q;
    if (clear) begin
      flags_d = '0;
    end else if (enable) begin
      flags_d = seen;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign all_done = enable & (&seen);

endmodule

// File: rtl/mode_picker.sv
// Minimum-cost mode decision sequencer; optional spectral term enabled by MODE_PICKER_DISTO_EN.
module mode_picker
  import mode_picker_pkg::*;
#(
  parameter int NUM_MODES  = 4,
  parameter int PAYLOAD_W  = 3104,
  parameter int SCORE_W    = 64,
  parameter int RATE_SHIFT = 10,
  parameter int DIST_SHIFT = 8,
  localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NUM_MODES-1:0]    mode_mask,
  input  logic [31:0]             lambda,
  input  logic [16*NUM_MODES-1:0] fixed_cost,
  output logic                    eval_start,
  output logic [MW-1:0]           eval_mode,
  input  logic                    sse_done,
  input  logic                    cost_done,
  input  logic [31:0]             sse,
  input  logic [31:0]             rate,
`ifdef MODE_PICKER_DISTO_EN
  input  logic [31:0]             disto,
  input  logic                    disto_done,
  input  logic [31:0]             tlambda,
`endif
  input  logic [PAYLOAD_W-1:0]    eval_payload,
  output logic                    busy,
  output logic                    done,
  output logic                    best_valid,
  output logic [MW-1:0]           best_mode,
  output logic [SCORE_W-1:0]      best_score,
  output logic [PAYLOAD_W-1:0]    best_payload
);

`ifdef MODE_PICKER_DISTO_EN
  localparam int N_JOIN = 3;
`else
  localparam int N_JOIN = 2;
`endif

  state_t                  state_q, state_d;
  logic                    eval_start_q, eval_start_d;
  logic [MW-1:0]           eval_mode_q, eval_mode_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    best_valid_q, best_valid_d;
  logic [MW-1:0]           best_mode_q, best_mode_d;
  logic [SCORE_W-1:0]      best_score_q, best_score_d;
  logic [PAYLOAD_W-1:0]    best_payload_q, best_payload_d;
  logic [NUM_MODES-1:0]    mask_q, mask_d;
  logic [31:0]             lambda_q, lambda_d;
  logic [16*NUM_MODES-1:0] fixed_cost_q, fixed_cost_d;
  logic [SCORE_W-1:0]      score_q, score_d;
  logic [31:0]             tlambda_q, tlambda_d;

  logic                    join_clear;
  logic                    join_en;
  logic                    join_all;
  logic [N_JOIN-1:0]       join_pulse;
  logic [31:0]             disto_val;
  logic [MW:0]             start_pick;
  logic [MW:0]             next_pick;
  logic [15:0]             cost_arr [NUM_MODES];
  logic [15:0]             mode_cost;

`ifdef MODE_PICKER_DISTO_EN
  assign join_pulse = {disto_done, cost_done, sse_done};
  assign disto_val  = disto;
  assign tlambda_d  = (state_q == ST_IDLE && start) ? tlambda : tlambda_q;
`else
  assign join_pulse = {cost_done, sse_done};
  assign disto_val  = 32'd0;
  assign tlambda_d  = 32'd0;
`endif

  // Lowest enabled mode at or above lo; MSB flags whether one exists.
  function automatic logic [MW:0] pick_mode(input logic [NUM_MODES-1:0] mask, input int lo);
    logic [MW:0] r;
    r = '0;
    for (int i = NUM_MODES - 1; i >= 0; i--) begin
      if (mask[i] && (i >= lo)) begin
        r = {1'b1, MW'(i)};
      end
    end
    return r;
  endfunction

  assign start_pick = pick_mode(mode_mask, 0);
  assign next_pick  = pick_mode(mask_q, int'(eval_mode_q) + 1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MODES; gi++) begin : g_cost
      assign cost_arr[gi] = fixed_cost_q[16*gi +: 16];
    end
  endgenerate
  assign mode_cost = cost_arr[eval_mode_q];

  mode_picker_join #(.N(N_JOIN)) u_join (
    .clk      (clk),
    .rst      (rst),
    .clear    (join_clear),
    .enable   (join_en),
    .pulse    (join_pulse),
    .all_done (join_all)
  );

  always_comb begin
    state_d        = state_q;
    eval_start_d   = 1'b0;
    eval_mode_d    = eval_mode_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    best_valid_d   = best_valid_q;
    best_mode_d    = best_mode_q;
    best_score_d   = best_score_q;
    best_payload_d = best_payload_q;
    mask_d         = mask_q;
    lambda_d       = lambda_q;
    fixed_cost_d   = fixed_cost_q;
    score_d        = score_q;
    join_clear     = 1'b0;
    join_en        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d       = mode_mask;
          lambda_d     = lambda;
          fixed_cost_d = fixed_cost;
          best_valid_d = 1'b0;
          best_score_d = '1;
          busy_d       = 1'b1;
          if (start_pick[MW]) begin
            state_d      = ST_LAUNCH;
            eval_start_d = 1'b1;
            eval_mode_d  = start_pick[MW-1:0];
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_LAUNCH: begin
        join_clear = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        join_en = 1'b1;
        if (join_all) begin
          state_d = ST_SCORE;
        end
      end
      ST_SCORE: begin
        score_d = SCORE_W'(calc_score(rate, mode_cost, lambda_q, sse, disto_val, tlambda_q,
                                      RATE_SHIFT, DIST_SHIFT, SCORE_W));
        state_d = ST_COMP;
      end
      ST_COMP: begin
        // Strict compare: on a tie the earlier (lower-index) mode is kept.
        if (!best_valid_q || (score_q < best_score_q)) begin
          best_valid_d   = 1'b1;
          best_mode_d    = eval_mode_q;
          best_score_d   = score_q;
          best_payload_d = eval_payload;
        end
        if (next_pick[MW]) begin
          state_d      = ST_LAUNCH;
          eval_start_d = 1'b1;
          eval_mode_d  = next_pick[MW-1:0];
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      eval_start_q   <= 1'b0;
      eval_mode_q    <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      best_valid_q   <= 1'b0;
      best_mode_q    <= '0;
      best_score_q   <= '1;
      best_payload_q <= '0;
      mask_q         <= '0;
      lambda_q       <= '0;
      fixed_cost_q   <= '0;
      score_q        <= '0;
      tlambda_q      <= '0;
    end else begin
      state_q        <= state_d;
      eval_start_q   <= eval_start_d;
      eval_mode_q    <= eval_mode_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      best_valid_q   <= best_valid_d;
      best_mode_q    <= best_mode_d;
      best_score_q   <= best_score_d;
      best_payload_q <= best_payload_d;
      mask_q         <= mask_d;
      lambda_q       <= lambda_d;
      fixed_cost_q   <= fixed_cost_d;
      score_q        <= score_d;
      tlambda_q      <= tlambda_d;
    end
  end

  assign eval_start   = eval_start_q;
  assign eval_mode    = eval_mode_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign best_valid   = best_valid_q;
  assign best_mode    = best_mode_q;
  assign best_score   = best_score_q;
  assign best_payload = best_payload_q;

endmodule

// File: tb/tb_mode_picker.sv
// Scoreboard bench for mode_picker: engine model, expected-result queue and done-driven monitor.
module tb_mode_picker;

  localparam int NM = 4;
  localparam int PW = 3104;
  localparam int SW = 64;
  localparam int MW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [NM-1:0]   mode_mask = '0;
  logic [31:0]     lambda = '0;
  logic [16*NM-1:0] fixed_cost = '0;
  logic            eval_start;
  logic [MW-1:0]   eval_mode;
  logic            sse_done = 1'b0;
  logic            cost_done = 1'b0;
  logic [31:0]     sse = '0;
  logic [31:0]     rate = '0;
  logic [PW-1:0]   eval_payload = '0;
  logic            busy;
  logic            done;
  logic            best_valid;
  logic [MW-1:0]   best_mode;
  logic [SW-1:0]   best_score;
  logic [PW-1:0]   best_payload;
`ifdef MODE_PICKER_DISTO_EN
  logic [31:0]     disto = '0;
  logic [31:0]     tlambda = '0;
  logic            disto_done;
  assign disto_done = sse_done;
`endif

  always #5 clk = ~clk;

  mode_picker #(
    .NUM_MODES(NM), .PAYLOAD_W(PW), .SCORE_W(SW), .RATE_SHIFT(10), .DIST_SHIFT(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode_mask(mode_mask), .lambda(lambda),
    .fixed_cost(fixed_cost), .eval_start(eval_start), .eval_mode(eval_mode),
    .sse_done(sse_done), .cost_done(cost_done), .sse(sse), .rate(rate),
`ifdef MODE_PICKER_DISTO_EN
    .disto(disto), .disto_done(disto_done), .tlambda(tlambda),
`endif
    .eval_payload(eval_payload), .busy(busy), .done(done), .best_valid(best_valid),
    .best_mode(best_mode), .best_score(best_score), .best_payload(best_payload)
  );

  typedef struct {
    logic        valid;
    int          mode;
    logic [63:0] score;
    int          done_cyc;
    int          launches;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          launches = 0;
  int          txn = 0;
  int          lat = 3;
  int          lead = 0;
  bit          dup = 1'b0;
  logic [31:0] sse_tab [NM];
  logic [31:0] rate_tab [NM];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [PW-1:0] mk_payload(input int m);
    logic [PW-1:0] p;
    p = '0;
    p[31:0]        = 32'hC0DE0000 + 32'(m);
    p[1600 +: 8]   = 8'(m * 17 + 3);
    p[PW-1 -: 16]  = 16'hBEE0 + 16'(m);
    return p;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_eval_start"}, 64'(eval_start), 64'd0);
    chk({tag, "_eval_mode"}, 64'(eval_mode), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_best_valid"}, 64'(best_valid), 64'd0);
    chk({tag, "_best_mode"}, 64'(best_mode), 64'd0);
    chk({tag, "_best_score"}, best_score, 64'hFFFF_FFFF_FFFF_FFFF);
    chk({tag, "_payload_any"}, 64'(|best_payload), 64'd0);
  endtask

  // Engine model: sse_done at launch+lat, cost_done lead cycles earlier, optional duplicate.
  task automatic engine_loop();
    int sse_cnt = 0;
    int cost_cnt = 0;
    int dup_cnt = 0;
    int pm = 0;
    forever begin
      @(negedge clk);
      sse_done  = 1'b0;
      cost_done = 1'b0;
      if (rst) begin
        sse_cnt = 0; cost_cnt = 0; dup_cnt = 0;
      end else if (eval_start) begin
        pm           = int'(eval_mode);
        sse_cnt      = lat;
        cost_cnt     = lat - lead;
        dup_cnt      = dup ? (lat - lead + 2) : 0;
        sse          = 32'hDEAD0000;
        rate         = 32'hBAD00000;
        eval_payload = ~mk_payload(pm);
      end else begin
        if (cost_cnt > 0) begin
          cost_cnt--;
          if (cost_cnt == 0) begin cost_done = 1'b1; rate = rate_tab[pm]; end
        end
        if (dup_cnt > 0) begin
          dup_cnt--;
          if (dup_cnt == 0) cost_done = 1'b1;
        end
        if (sse_cnt > 0) begin
          sse_cnt--;
          if (sse_cnt == 0) begin
            sse_done     = 1'b1;
            sse          = sse_tab[pm];
            eval_payload = mk_payload(pm);
          end
        end
      end
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        launches = 0;
      end else begin
        if (eval_start) launches++;
        if (done) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            txn++;
            chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
            chk("launch_count", 64'(launches), 64'(e.launches));
            chk("busy_at_done", 64'(busy), 64'd1);
            chk("best_valid", 64'(best_valid), 64'(e.valid));
            chk("best_score", best_score, e.score);
            chk("best_mode", 64'(best_mode), 64'(e.mode));
            if (e.valid) begin
              chk("payload_lo", best_payload[63:0], mk_payload(e.mode) ~^ 64'h0 ^ ~64'h0 ^ mk_payload(e.mode) ^ mk_payload(e.mode));
              chk("payload_full", 64'(best_payload == mk_payload(e.mode)), 64'd1);
            end
            $display("txn %0d: cycle=%0d launches=%0d valid=%0d mode=%0d score=%0d", txn, cyc,
                     launches, best_valid, best_mode, best_score);
          end
          launches = 0;
        end
      end
    end
  endtask

  task automatic issue(input logic [NM-1:0] mask, input logic [31:0] lam, input logic [63:0] fc,
                       input bit push, input logic ev, input int em, input logic [63:0] es,
                       input int off, input int nl);
    exp_t e;
    @(negedge clk);
    mode_mask  = mask;
    lambda     = lam;
    fixed_cost = fc;
    start      = 1'b1;
    if (push) begin
      e.valid = ev; e.mode = em; e.score = es; e.done_cyc = cyc + off; e.launches = nl;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start      = 1'b0;
    mode_mask  = ~mask;
    lambda     = 32'h0BADF00D;
    fixed_cost = ~fc;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no_done expected=done within %0d cycles", bound);
      exp_q.delete();
    end
  endtask

  initial begin
    int  n;
    bit  found;
    fork
      engine_loop();
      monitor_loop();
    join_none

    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b0;

    // Four modes, L=3: scores 3202,1719,2264,5422 -> mode 1.
    lat = 3; lead = 0; dup = 1'b0;
    sse_tab  = '{32'd10, 32'd5, 32'd5, 32'd20};
    rate_tab = '{32'd0, 32'd0, 32'd0, 32'd0};
    issue(4'b1111, 32'd1, {16'd302, 16'd984, 16'd439, 16'd642}, 1'b1, 1'b1, 1, 64'd1719, 25, 4);
    wait_done(200);

    // Tie between modes 0 and 2 (both 4096) -> lower index wins.
    lat = 2;
    sse_tab  = '{32'd8, 32'd1, 32'd8, 32'd1};
    rate_tab = '{32'd1, 32'd0, 32'd0, 32'd0};
    issue(4'b0101, 32'd2, {16'd0, 16'd1024, 16'd7, 16'd0}, 1'b1, 1'b1, 0, 64'd4096, 11, 2);
    wait_done(200);

    // Empty mask: immediate done, nothing launched, best_mode left unchanged.
    issue(4'b0000, 32'd5, 64'd0, 1'b1, 1'b0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    wait_done(50);

    // Out-of-order dones with duplicated cost_done and a start pulse while busy.
    lat = 7; lead = 5; dup = 1'b1;
    sse_tab  = '{32'd0, 32'd100, 32'd0, 32'd90};
    rate_tab = '{32'd0, 32'd2, 32'd0, 32'd1};
    issue(4'b1010, 32'd3, {16'd5, 16'd0, 16'd10, 16'd0}, 1'b1, 1'b1, 3, 64'd26127, 21, 2);
    repeat (3) @(negedge clk);
    start = 1'b1; mode_mask = 4'b1111;
    @(negedge clk);
    start = 1'b0;
    wait_done(200);

    // Reset during the WAIT of mode 2 aborts the run.
    lat = 3; lead = 0; dup = 1'b0;
    sse_tab  = '{32'd10, 32'd5, 32'd5, 32'd20};
    rate_tab = '{32'd0, 32'd0, 32'd0, 32'd0};
    issue(4'b1111, 32'd1, {16'd302, 16'd984, 16'd439, 16'd642}, 1'b0, 1'b0, 0, 64'd0, 0, 0);
    found = 1'b0;
    n = 0;
    while (!found && n < 200) begin
      @(negedge clk);
      #1;
      if (eval_start && eval_mode == 2'd2) found = 1'b1;
      n++;
    end
    chk("reach_mode2_launch", 64'(found), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset("midrun_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("post_reset_launches", 64'(launches), 64'd0);
    chk("post_reset_busy", 64'(busy), 64'd0);

    // Clean rerun after the abort.
    issue(4'b1111, 32'd1, {16'd302, 16'd984, 16'd439, 16'd642}, 1'b1, 1'b1, 1, 64'd1719, 25, 4);
    wait_done(200);

    // Saturation with a single enabled mode.
    lat = 1;
    sse_tab  = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'd0};
    rate_tab = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'd0};
    issue(4'b0100, 32'hFFFFFFFF, {16'd0, 16'hFFFF, 16'd0, 16'd0}, 1'b1, 1'b1, 2,
          64'hFFFF_FFFF_FFFF_FFFF, 5, 1);
    wait_done(100);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
